// File: rtl/scan_sel_gen_if.sv
// Control and select bundle between the scan sequencer and whoever drives it.
// The sequencer uses the slave modport; the controller or testbench uses master.
interface scan_sel_gen_if #(
    parameter int DIV_W = 16
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic [3:0]       mask;
    logic [1:0]       sel;
    logic             en;
    logic             busy;
    logic             pass_done;

    modport master (
        output start, stop, mode, div, mask,
        input  sel, en, busy, pass_done
    );

    modport slave (
        input  start, stop, mode, div, mask,
        output sel, en, busy, pass_done
    );
endinterface

// File: rtl/scan_sel_gen.sv
// Timed channel sequencer feeding a 2-to-4 decoder (sel -> in, en -> en).
// Optional macro SCAN_BLANK_EN blanks en for the first cycle of each dwell when div>=1.
module scan_sel_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    scan_sel_gen_if.slave    bus
);
`ifdef SCAN_BLANK_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] div_l;
    logic             mode_l;

    logic             tick;
    logic [1:0]       nxt;
    logic             wrap;

    function automatic logic [1:0] low_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    // Search upward from c with wraparound; a lone enabled channel maps to itself.
    function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] r;
        logic [1:0] idx;
        r = c;
        for (int k = 3; k >= 1; k--) begin
            idx = c + 2'(k);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    always_comb begin
        tick = (presc == div_l);
        nxt  = next_bit(bus.mask, bus.sel);
        wrap = (nxt <= bus.sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.sel       <= 2'b00;
            bus.en        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.pass_done <= 1'b0;
            presc         <= '0;
            mode_l        <= 1'b0;
            div_l         <= '0;
        end else begin
            bus.pass_done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.en   <= 1'b0;
                    bus.busy <= 1'b0;
                    if (bus.start && !bus.stop && (bus.mask != 4'b0000)) begin
                        state    <= RUN;
                        bus.sel  <= low_bit(bus.mask);
                        bus.en   <= !BLANK || (bus.div == '0);
                        bus.busy <= 1'b1;
                        presc    <= '0;
                        mode_l   <= bus.mode;
                        div_l    <= bus.div;
                    end
                end
                RUN: begin
                    if (bus.stop || (bus.mask == 4'b0000)) begin
                        state    <= IDLE;
                        bus.en   <= 1'b0;
                        bus.busy <= 1'b0;
                        presc    <= '0;
                    end else if (tick) begin
                        presc         <= '0;
                        bus.pass_done <= wrap;
                        if (wrap && mode_l) begin
                            state    <= IDLE;
                            bus.en   <= 1'b0;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.sel <= nxt;
                            bus.en  <= !BLANK || (div_l == '0);
                        end
                    end else begin
                        presc  <= presc + 1'b1;
                        bus.en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed scoreboard bench for scan_sel_gen: driver pushes expected outputs, monitor pops.
// Expected en tracks SCAN_BLANK_EN so the bench fits either build.
module tb_scan_sel_gen;
`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       pd;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    scan_sel_gen_if #(.DIV_W(16)) bus ();
    scan_sel_gen #(.DIV_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc(input logic s, input logic p, input logic md, input logic [15:0] d,
                       input logic [3:0] m, input logic r, input logic [1:0] es,
                       input logic ee, input logic eb, input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        bus.start = s; bus.stop = p; bus.mode = md; bus.div = d; bus.mask = m; rst = r;
        e.sel = es; e.en = ee; e.busy = eb; e.pd = ep; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (bus.sel !== e.sel || bus.en !== e.en || bus.busy !== e.busy || bus.pass_done !== e.pd) begin
                    bad++;
                    $display("FAIL %s: got sel=%0d en=%0d busy=%0d pd=%0d, want sel=%0d en=%0d busy=%0d pd=%0d",
                             e.name, bus.sel, bus.en, bus.busy, bus.pass_done, e.sel, e.en, e.busy, e.pd);
                end
            end
        end
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.div = 0; bus.mask = 0;
        // reset and idle
        cyc(0, 0, 0, 0, 4'b0000, 1, 2'd0, 0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 4'b0000, 1, 2'd0, 0, 0, 0, "reset");
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 0, 4'b1111, 0, 2'd0, 0, 0, 0, "idle");

        // continuous, all channels, div=2
        for (int i = 0; i < 13; i++)
            cyc(i == 0, 0, 0, 16'd2, 4'b1111, 0, 2'((i / 3) % 4),
                !(BLANK && (i % 3 == 0)), 1, i == 12, "cont_1111");
        cyc(0, 1, 0, 16'd2, 4'b1111, 0, 2'd0, 0, 0, 0, "stop_mid");

        // stop on the same cycle as the wrap tick, div=0
        for (int i = 0; i < 4; i++)
            cyc(i == 0, 0, 0, 16'd0, 4'b1111, 0, 2'(i), 1, 1, 0, "cont_div0");
        cyc(0, 1, 0, 16'd0, 4'b1111, 0, 2'd3, 0, 0, 0, "stop_wrap");

        // single pass over channels 1 and 3, div=0
        cyc(1, 0, 1, 16'd0, 4'b1010, 0, 2'd1, 1, 1, 0, "single_ch1");
        cyc(0, 0, 0, 16'd0, 4'b1010, 0, 2'd3, 1, 1, 0, "single_ch3");
        cyc(0, 0, 0, 16'd0, 4'b1010, 0, 2'd3, 0, 0, 1, "single_done");
        cyc(0, 0, 0, 16'd0, 4'b1010, 0, 2'd3, 0, 0, 0, "single_idle");

        // lone channel 2, div=1: wraps onto itself every 2 cycles
        for (int i = 0; i < 7; i++)
            cyc(i == 0, 0, 0, 16'd1, 4'b0100, 0, 2'd2,
                !(BLANK && (i % 2 == 0)), 1, (i >= 2) && (i % 2 == 0), "lone_ch2");
        cyc(0, 1, 0, 16'd1, 4'b0100, 0, 2'd2, 0, 0, 0, "lone_stop");

        // ignored starts
        cyc(1, 0, 0, 16'd0, 4'b0000, 0, 2'd2, 0, 0, 0, "start_mask0");
        cyc(1, 1, 0, 16'd0, 4'b1111, 0, 2'd2, 0, 0, 0, "start_and_stop");

        // mask dropping to zero aborts, start in RUN ignored
        cyc(1, 0, 0, 16'd0, 4'b0011, 0, 2'd0, 1, 1, 0, "mask_run");
        cyc(1, 0, 0, 16'd0, 4'b0011, 0, 2'd1, 1, 1, 0, "start_in_run");
        cyc(0, 0, 0, 16'd0, 4'b0000, 0, 2'd1, 0, 0, 0, "mask_abort");

        // div=3 over channels 0,1 (blank pattern 0,1,1,1 when enabled)
        for (int i = 0; i < 9; i++)
            cyc(i == 0, 0, 0, 16'd3, 4'b0011, 0, 2'((i / 4) % 2),
                !(BLANK && (i % 4 == 0)), 1, i == 8, "div3_0011");

        // reset mid-scan
        cyc(0, 0, 0, 16'd3, 4'b0011, 1, 2'd0, 0, 0, 0, "reset_mid");
        cyc(0, 0, 0, 16'd3, 4'b0011, 0, 2'd0, 0, 0, 0, "after_reset");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Timed channel sequencer that sits directly upstream of the 2-to-4 decoder.
- Generates the 2-bit select `sel` and the enable `en`, which drive the decoder's `in` and `en` inputs.
- Steps through the enabled channels (per `mask`) at a programmable dwell rate, either in continuous scan or as a single pass.
- Typical use: digit/row scanning for multiplexed displays and keypads.

Parameters:
- DIV_W, 16, width of the dwell divider; dwell per channel = div+1 clock cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin scan; level-sampled, acted on only in IDLE
- stop  input  1  abort scan; highest priority
- mode  input  1  0 = continuous scan, 1 = single pass; latched at start
- div  input  DIV_W  dwell count; latched at start
- mask  input  4  channel enables, bit i = channel i; sampled live every cycle
- sel  output  2  current channel index, to decoder `in`
- en  output  1  select valid, to decoder `en`
- busy  output  1  high while in RUN
- pass_done  output  1  one-cycle pulse when a full pass of the enabled channels completes

Behaviour:
- Interface: one clock (`clk`); reset (`rst`) is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, sel=2'b00, en=0, busy=0, pass_done=0, prescaler=0, latched mode=0, latched div=0.
- States: IDLE, RUN.
- IDLE:
  - en=0, busy=0; sel holds its last value.
  - start=1, stop=0, mask!=0 in cycle N -> RUN in cycle N+1 with sel = lowest set bit of mask, en=1, busy=1, prescaler=0. mode and div are latched in cycle N.
  - start with mask==0 is ignored.
  - start and stop both high -> stay IDLE.
- RUN:
  - Prescaler increments each cycle. When prescaler==latched div (a tick), it clears and the channel advances.
  - Advance: sel <= next set bit of mask strictly above sel, searching 0..3 cyclically.
  - A wrap occurs when the next set index <= current sel. This includes the case where only one channel is enabled: sel is reloaded with the same value and it still counts as a wrap.
  - On a wrap tick: pass_done=1 for that one cycle.
    - Continuous mode: sel updates and RUN continues.
    - Single mode: go to IDLE next cycle, en=0, busy=0, sel holds the last channel.
  - div=0: advance every cycle; each channel is valid for exactly 1 cycle.
- Abort conditions in RUN:
  - stop=1: IDLE next cycle, en=0, busy=0, no pass_done, even if a tick or wrap occurs in the same cycle.
  - mask==0: IDLE next cycle, no pass_done.
- start asserted while in RUN is ignored; there is no restart.
- Dwell: each visited channel holds sel for exactly div+1 cycles.
- Reset mid-scan: all state returns to reset values on the next edge; no pass_done.

Optional Feature:
- Macro: SCAN_BLANK_EN
- Defined:
  - When latched div>=1, en=0 for the first cycle of every channel dwell, including the first channel after start.
  - sel changes during this blank cycle; en=1 for the remaining div cycles.
  - pass_done timing is unchanged.
  - With div=0 there is no blanking.
- Undefined: en stays continuously high throughout RUN.

Test Plan:
- Reset, then idle with start=0 -> sel=0, en=0, busy=0, pass_done=0 for 10 cycles.
- mask=4'b1111, div=2, mode=0, start pulse -> sel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 with en=1 throughout; pass_done high on the cycle sel goes 3->0.
- mask=4'b1010, div=0, mode=1, start pulse -> sel=1 then 3 (one cycle each); pass_done pulse on the next tick; IDLE next cycle with en=0, busy=0, sel=3.
- Continuous scan with mask=4'b0100 -> sel stays at 2; pass_done pulses every div+1 cycles.
- stop asserted mid-dwell (and, separately, stop coincident with a wrap tick) -> en=0, busy=0 next cycle, no pass_done. Separately: start with mask=0 -> no state change.
- SCAN_BLANK_EN defined, div=3, mask=4'b0011 -> per channel, en pattern is 0,1,1,1 while sel is constant; div=0 -> en=1 continuously.
